// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: handshake bundle between N requesting channels, the arbiter and one consumer.
// Latency: none; plain wires.
// Backpressure: carried by in_ready (per channel) and out_ready (consumer).
// Ports: in_valid/in_data/in_ready (channel side), out_valid/out_data/out_sel/out_ready (consumer side).
// Modports: slave = arbiter view, master = producer/consumer (testbench) view.
interface rr_arb_mux_if #(
  parameter int width    = 16,
  parameter int channels = 4,
  parameter int selw     = $clog2(channels)
);
  logic [channels-1:0]       in_valid;
  logic [channels*width-1:0] in_data;
  logic [channels-1:0]       in_ready;
  logic                      out_valid;
  logic [width-1:0]          out_data;
  logic [selw-1:0]           out_sel;
  logic                      out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin N:1 arbiter feeding a single-entry output register.
// Latency: one cycle from input transfer to out_valid; one beat per cycle sustained, no bubble.
// Backpressure: out_valid & !out_ready holds the register and forces all in_ready low.
// Ports: clk, rst_n (async active-low), bus (rr_arb_mux_if.slave).
// Config: define RR_ARB_MUX_FIXED_PRIO_EN for lowest-index-wins priority (no rotating pointer).
module rr_arb_mux #(
  parameter int width    = 16,
  parameter int channels = 4,
  parameter int selw     = $clog2(channels)
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arb_mux_if.slave bus
);

  logic [channels-1:0] grant;
  logic [selw-1:0]     gidx;
  logic                load_en;
  logic                in_xfer;

  // Register can take a new beat when empty or being drained this cycle.
  assign load_en = !bus.out_valid | bus.out_ready;

  // Gating with rst_n keeps in_ready quiet while the register is held in reset.
  assign bus.in_ready = (rst_n && load_en) ? grant : '0;
  assign in_xfer      = |bus.in_ready;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN

  // Scan downward so the lowest-index valid channel is the last writer.
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int k = channels - 1; k >= 0; k--) begin
      if (bus.in_valid[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        gidx     = selw'(k);
      end
    end
  end

`else

  logic [selw-1:0] ptr;

  // Visit offsets from ptr in descending order so the smallest offset
  // (first valid channel at or after ptr, wrapping) is the last writer.
  always_comb begin
    int idx;
    grant = '0;
    gidx  = '0;
    idx   = 0;
    for (int k = channels - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= channels) idx = idx - channels;
      if (bus.in_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gidx       = selw'(idx);
      end
    end
  end

  // Pointer moves just past the winner only when a beat is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (in_xfer) begin
      ptr <= (gidx == selw'(channels - 1)) ? '0 : gidx + selw'(1);
    end
  end

`endif

  // Single-entry output register; a simultaneous drain and load replaces the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
    end else if (in_xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[gidx*width +: width];
      bus.out_sel   <= gidx;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
